// File: rtl/icache_tag_ctrl_pkg.sv
// Shared definitions for the icache tag path: entry layout, sizes and controller states.
package icache_tag_ctrl_pkg;

    localparam int TAG_VALID_BIT = 22;
    localparam int TAG_SETS      = 64;

    typedef struct packed {
        logic        valid;
        logic [21:0] tag;
    } tag_entry_t;

    typedef enum logic {
        ST_SWEEP,
        ST_READY
    } state_t;

endpackage

// File: rtl/icache_tag_array.sv
// Single-port tag SRAM: inputs registered on posedge, read data combinational from the
// registered address, writes commit on the posedge after they were presented.
module icache_tag_array #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 23
) (
    input  logic                  clk,
    input  logic                  csb,
    input  logic                  web,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic                  csb_q;
    logic                  web_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;

    always_ff @(posedge clk) begin
        csb_q  <= csb;
        web_q  <= web;
        addr_q <= addr;
        din_q  <= din;
        if (!csb_q && !web_q) begin
            mem[addr_q] <= din_q;
        end
    end

    assign dout = mem[addr_q];

endmodule

// File: rtl/icache_tag_ctrl.sv
// Tag SRAM port controller: invalidate sweep after reset/flush, fill-over-lookup
// arbitration, and a hit/miss response one cycle after each accepted lookup.
//
//   state    | meaning
//   ST_SWEEP | writing zero to every entry, one per cycle; no requests accepted
//   ST_READY | serving flush > fill > lookup
module icache_tag_ctrl
    import icache_tag_ctrl_pkg::*;
#(
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_WIDTH   = 22,
    parameter int DATA_WIDTH  = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    output logic                   init_done,
    input  logic                   lookup_valid,
    output logic                   lookup_ready,
    input  logic [INDEX_WIDTH-1:0] lookup_index,
    input  logic [TAG_WIDTH-1:0]   lookup_tag,
    output logic                   resp_valid,
    output logic                   resp_hit,
    output logic [TAG_WIDTH-1:0]   resp_stored_tag,
    input  logic                   fill_valid,
    output logic                   fill_ready,
    input  logic [INDEX_WIDTH-1:0] fill_index,
    input  logic [TAG_WIDTH-1:0]   fill_tag,
    output logic                   sram_csb,
    output logic                   sram_web,
    output logic [INDEX_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    state_t                 state;
    logic [INDEX_WIDTH-1:0] cnt;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic                   lookup_fire;

    assign lookup_fire = lookup_valid && lookup_ready;
    assign init_done   = (state == ST_READY) && !rst;

    // SRAM port is driven combinationally so the access lands in the accept cycle.
    always_comb begin
        sram_csb     = 1'b1;
        sram_web     = 1'b1;
        sram_addr    = '0;
        sram_din     = '0;
        fill_ready   = 1'b0;
        lookup_ready = 1'b0;
        if (!rst) begin
            case (state)
                ST_SWEEP: begin
                    sram_csb  = 1'b0;
                    sram_web  = 1'b0;
                    sram_addr = cnt;
                end
                ST_READY: begin
                    if (!flush) begin
                        fill_ready   = 1'b1;
                        lookup_ready = !fill_valid;
                        if (fill_valid) begin
                            sram_csb  = 1'b0;
                            sram_web  = 1'b0;
                            sram_addr = fill_index;
                            sram_din  = {1'b1, fill_tag};
                        end else if (lookup_valid) begin
                            sram_csb  = 1'b0;
                            sram_addr = lookup_index;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_SWEEP;
            cnt        <= '0;
            resp_valid <= 1'b0;
            tag_q      <= '0;
        end else begin
            resp_valid <= lookup_fire;
            if (lookup_fire) begin
                tag_q <= lookup_tag;
            end
            case (state)
                ST_SWEEP: begin
                    if (cnt == {INDEX_WIDTH{1'b1}}) begin
                        state <= ST_READY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + INDEX_WIDTH'(1);
                    end
                end
                ST_READY: begin
                    if (flush) begin
                        state <= ST_SWEEP;
                    end
                end
                default: state <= ST_SWEEP;
            endcase
        end
    end

    // SRAM output still reflects the address of the previous cycle's lookup.
    assign resp_hit        = sram_dout[DATA_WIDTH-1] && (sram_dout[TAG_WIDTH-1:0] == tag_q);
    assign resp_stored_tag = sram_dout[TAG_WIDTH-1:0];

endmodule
